// File: rtl/cas_player.sv
// Cassette playback generator: turns a tape byte stream into the Laser 500 CASIN waveform
// (leader tone, long sync cycle, MSB-first data bits, long trailer cycle).
module cas_player #(
  parameter int unsigned SHORT_HALF    = 1848,
  parameter int unsigned LONG_HALF     = 3696,
  parameter int unsigned LEADER_PULSES = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        F14M,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        motor,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        casin,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam int unsigned PulseW = (LEADER_PULSES > 1) ? $clog2(LEADER_PULSES) : 1;
  localparam logic [CNT_W-1:0]  ShortLd   = CNT_W'(SHORT_HALF - 1);
  localparam logic [CNT_W-1:0]  LongLd    = CNT_W'(LONG_HALF - 1);
  localparam logic [PulseW-1:0] LastPulse = PulseW'(LEADER_PULSES - 1);

  typedef enum logic [2:0] {
    StIdle, StLeader, StSync, StFetch, StBits, StTrailer
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic               r_phase;    // 0: high half, 1: low half
  logic [PulseW-1:0]  r_pulse;
  logic [2:0]         r_bit_idx;
  logic               r_sub;      // second short cycle of a '1' bit
  logic [7:0]         r_data;
  logic               r_last;
  logic [15:0]        r_count;
  logic               r_casin;
  logic               r_ready;
  logic               r_busy;

  logic               w_timer_zero;
  logic               w_cur_bit;
  logic [2:0]         w_next_idx;
  logic               w_next_bit;
  logic [CNT_W-1:0]   w_half_ld;

  assign w_timer_zero = (r_timer == '0);
  assign w_cur_bit    = r_data[r_bit_idx];
  assign w_next_idx   = r_bit_idx - 3'd1;
  assign w_next_bit   = r_data[w_next_idx];
  assign w_half_ld    = (r_state == StLeader || (r_state == StBits && w_cur_bit)) ?
                        ShortLd : LongLd;

  always_ff @(posedge F14M or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_phase   <= 1'b0;
      r_pulse   <= '0;
      r_bit_idx <= '0;
      r_sub     <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_count   <= '0;
      r_casin   <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else if (stop) begin
      r_state <= StIdle;
      r_casin <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else if (r_state == StIdle) begin
      if (start) begin
        r_state <= StLeader;
        r_timer <= ShortLd;
        r_phase <= 1'b0;
        r_pulse <= '0;
        r_count <= '0;
        r_casin <= 1'b1;
        r_busy  <= 1'b1;
      end
    end else if (!motor) begin
      // Frozen: everything holds, outputs are silenced until the motor returns.
      r_casin <= 1'b0;
      r_ready <= 1'b0;
    end else if (r_state == StFetch) begin
      r_casin <= 1'b0;
      if (!r_ready) begin
        r_ready <= 1'b1;
      end else if (byte_valid) begin
        r_ready   <= 1'b0;
        r_data    <= byte_data;
        r_last    <= byte_last;
        r_count   <= r_count + 16'd1;
        r_bit_idx <= 3'd7;
        r_sub     <= 1'b0;
        r_phase   <= 1'b0;
        r_timer   <= byte_data[7] ? ShortLd : LongLd;
        r_casin   <= 1'b1;
        r_state   <= StBits;
      end
    end else if (!w_timer_zero) begin
      r_timer <= r_timer - CNT_W'(1);
      r_casin <= ~r_phase;
    end else if (!r_phase) begin
      r_phase <= 1'b1;
      r_casin <= 1'b0;
      r_timer <= w_half_ld;
    end else begin
      // End of a full cycle: decide what the next cycle is.
      r_phase <= 1'b0;
      case (r_state)
        StLeader: begin
          r_casin <= 1'b1;
          if (r_pulse == LastPulse) begin
            r_state <= StSync;
            r_timer <= LongLd;
          end else begin
            r_pulse <= r_pulse + PulseW'(1);
            r_timer <= ShortLd;
          end
        end
        StSync: begin
          r_state <= StFetch;
          r_casin <= 1'b0;
          r_ready <= 1'b1;
        end
        StBits: begin
          if (w_cur_bit && !r_sub) begin
            r_sub   <= 1'b1;
            r_timer <= ShortLd;
            r_casin <= 1'b1;
          end else if (r_bit_idx == 3'd0) begin
            if (r_last) begin
              r_state <= StTrailer;
              r_timer <= LongLd;
              r_casin <= 1'b1;
            end else begin
              r_state <= StFetch;
              r_casin <= 1'b0;
              r_ready <= 1'b1;
            end
          end else begin
            r_bit_idx <= w_next_idx;
            r_sub     <= 1'b0;
            r_timer   <= w_next_bit ? ShortLd : LongLd;
            r_casin   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_casin <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign casin      = r_casin;
  assign busy       = r_busy;
  assign byte_count = r_count;

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback generator for the Laser 500 core. It consumes a byte stream of a tape image, buffered from the ioctl download path, over a valid/ready handshake. It emits the 1-bit tape waveform that drives the `CASIN` latch feeding the VTL chip, so the core can "LOAD" from a virtual tape. The block generates the leader tone, a sync cycle, MSB-first data bits and a trailer cycle, all timed in `F14M` cycles.

## Interface
Parameters:
- `SHORT_HALF`, 1848: half-period of a short cycle, in `F14M` cycles (≥2).
- `LONG_HALF`, 3696: half-period of a long cycle, in `F14M` cycles; must equal 2×`SHORT_HALF`.
- `LEADER_PULSES`, 1024: number of full short cycles in the leader (≥1).
- `CNT_W`, 16: width of the phase timer; must hold `LONG_HALF`−1.

Ports:
- `F14M` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin playback; honoured only in IDLE.
- `stop` in 1: abort playback; return to IDLE on the next edge.
- `motor` in 1: cassette motor level; 0 freezes playback.
- `byte_valid` in 1: `byte_data`/`byte_last` hold a valid byte.
- `byte_data` in 8: tape byte.
- `byte_last` in 1: marks the final byte of the image.
- `byte_ready` out 1: the block accepts a byte this cycle.
- `casin` out 1: tape waveform.
- `busy` out 1: high in every state except IDLE.
- `byte_count` out 16: number of bytes accepted since the last `start`.

## Operation
- FSM states: IDLE, LEADER, SYNC, FETCH, BITS, TRAILER.
- Cycle primitive: `casin`=1 for a half-period, then 0 for a half-period. The phase timer loads half−1 and counts down; at 0 it either toggles phase or ends the cycle.
- IDLE: `casin`=0, `byte_ready`=0. `start` moves to LEADER, clears `byte_count` and the pulse counter.
- LEADER: emits `LEADER_PULSES` short cycles, then moves to SYNC.
- SYNC: emits one long cycle, then moves to FETCH.
- FETCH: `byte_ready`=1 (registered, state-decoded) and `casin`=0.
  - When `byte_valid` is high, the block latches data and last, increments `byte_count` (wraps at 0xFFFF→0) and moves to BITS.
  - When `byte_valid` is low (underrun), the block waits in FETCH with `casin` held low.
- BITS: 8 bits, MSB first.
  - Bit 1 = two short cycles.
  - Bit 0 = one long cycle.
  - Every bit lasts 4×`SHORT_HALF` clocks.
  - After bit 0 (LSB), the block goes to TRAILER if the latched last flag is set, else to FETCH.
- TRAILER: emits one long cycle, then moves to IDLE.
- `motor`=0 in any non-IDLE state:
  - The timer, bit and pulse counters and the FSM freeze.
  - `casin` is forced to 0 and `byte_ready` is forced to 0.
  - When `motor` returns to 1, playback resumes with the remaining count and the saved phase.
- `stop`: from any state, the block goes to IDLE on the next edge with `casin`=0 and `byte_ready`=0. `byte_count` is retained.
- `start` and `stop` asserted in the same cycle: `stop` wins and the block stays in IDLE.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: state IDLE, `casin`=0, `byte_ready`=0, `busy`=0, `byte_count`=0, all counters 0.
- Reset asserted mid-operation aborts immediately (asynchronously). No byte is consumed during reset.
- `start` sampled at edge N: `busy`=1 and `casin`=1 from N+1. The first high phase lasts exactly `SHORT_HALF` clocks.
- Leader duration is 2×`SHORT_HALF`×`LEADER_PULSES` clocks. SYNC lasts 2×`LONG_HALF` clocks.
- FETCH lasts a minimum of 1 clock, so there is exactly one low clock between consecutive bytes when `byte_valid` is held high.
- Handshake: a transfer occurs on an edge where `byte_ready`&&`byte_valid`; at most one byte per FETCH visit. `byte_data` is ignored when `byte_ready`=0.
- The first BITS high phase starts on the clock after the transfer.
- `busy` falls on the edge that ends the TRAILER low phase.

## Test plan
Parameters for all scenarios: `SHORT_HALF`=4, `LONG_HALF`=8, `LEADER_PULSES`=2.
- Reset: assert `reset` mid-BITS -> `casin`=0, `busy`=0, `byte_ready`=0, `byte_count`=0 immediately; the block remains idle after release.
- Single byte 0xA5, `byte_last`=1, `byte_valid` held high, `start` at cycle 0 ->
  - `casin` high at cycles 1–4, 9–12 (leader) and 17–24 (sync).
  - `byte_ready`=1 at cycle 33.
  - Bit waveform order is 1,0,1,0,0,1,0,1, each bit 16 clocks.
  - Trailer long cycle follows; `busy`=0 at cycle 178; `byte_count`=1.
- Two bytes 0x00 then 0xFF (last on 0xFF), `byte_valid` held low for 10 cycles before the second byte -> `casin` stays low for 11 clocks in FETCH, then the second byte plays; `byte_count`=2.
- `motor`=0 for 20 cycles after 2 clocks into a bit-0 high phase -> `casin`=0 for those 20 cycles, then high for the remaining 6 clocks; total bit length is 16 + 20.
- `stop` in the middle of the second bit -> IDLE on the next edge with `casin`=0; a new `start` replays the leader and resets `byte_count` to 0.
- `start`+`stop` in the same cycle in IDLE -> `busy` stays 0. `start` pulsed during LEADER -> no restart; the leader completes in 16 clocks.
